// File: rtl/btb_write_scheduler_pkg.sv
// Shared types for the BTB write scheduler: index width default, state
// encoding and the buffered update entry.
package btb_pkg;
    localparam int LOWER = 5;
    localparam int TAG_W = 64 - LOWER;

    typedef enum logic {IDLE, FLUSH} state_t;

    // pc_sw is {pc[LOWER-1:0], pc[63:LOWER]}: index bits on top, tag below,
    // so the entry layout does not depend on LOWER.
    typedef struct packed {
        logic [63:0] pc_sw;
        logic [63:0] target;
        logic        taken;
    } upd_entry_t;
endpackage

// File: rtl/btb_write_scheduler_if.sv
// Update, flush and BTB write-port signals of the scheduler.
interface btb_write_scheduler_if #(parameter int LOWER = btb_pkg::LOWER);
    logic              upd_valid;
    logic              upd_ready;
    logic [63:0]       upd_pc;
    logic [63:0]       upd_target;
    logic              upd_taken;
    logic              flush_req;
    logic              flush_busy;
    logic              flush_done;
    logic              pred_inhibit;
    logic              wr_stall;
    logic              wr_en;
    logic [LOWER-1:0]  wr_index;
    logic [63-LOWER:0] wr_tag;
    logic [63:0]       wr_target;
    logic              wr_valid;

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_taken, flush_req, wr_stall,
        output upd_ready, flush_busy, flush_done, pred_inhibit,
               wr_en, wr_index, wr_tag, wr_target, wr_valid
    );
    modport master (
        output upd_valid, upd_pc, upd_target, upd_taken, flush_req, wr_stall,
        input  upd_ready, flush_busy, flush_done, pred_inhibit,
               wr_en, wr_index, wr_tag, wr_target, wr_valid
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// Small update FIFO with wrap-bit pointers; clr empties it synchronously.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  upd_entry_t din,
    output upd_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    upd_entry_t     mem [DEPTH];
    logic [AW:0]    wp;
    logic [AW:0]    rp;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head    = mem[rp[AW-1:0]];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/btb_write_scheduler.sv
// Sequences buffered branch updates and full-table invalidation sweeps onto
// the BTB's single write port.
module btb_write_scheduler
    import btb_pkg::*;
#(
    parameter int LOWER      = btb_pkg::LOWER,
    parameter int FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  arst_n,
    btb_write_scheduler_if.slave bus
);
    state_t            state;
    logic [LOWER-1:0]  cnt;
    logic              done_q;
    logic              idle;
    logic              push;
    logic              pop;
    logic              clr;
    logic              full;
    logic              empty;
    upd_entry_t        din;
    upd_entry_t        head;

    logic              wr_en;
    logic [LOWER-1:0]  wr_index;
    logic [63-LOWER:0] wr_tag;
    logic [63:0]       wr_target;
    logic              wr_valid;

    assign idle          = (state == IDLE);
    assign bus.upd_ready = idle && !full && !bus.flush_req;
    assign push          = bus.upd_valid && bus.upd_ready;
    assign pop           = idle && !empty && !bus.wr_stall;
    // Queued updates describe pre-flush state, so flush entry drops them.
    assign clr           = idle && bus.flush_req;

    assign din.pc_sw  = {bus.upd_pc[LOWER-1:0], bus.upd_pc[63:LOWER]};
    assign din.target = bus.upd_target;
    assign din.taken  = bus.upd_taken;

    btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    if (!bus.wr_stall) begin
                        if (&cnt) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_index  = '0;
        wr_tag    = '0;
        wr_target = '0;
        wr_valid  = 1'b0;
        if (state == FLUSH) begin
            wr_en    = 1'b1;
            wr_index = cnt;
        end else if (!empty) begin
            wr_en     = 1'b1;
            wr_index  = head.pc_sw[63 -: LOWER];
            wr_tag    = head.pc_sw[63-LOWER:0];
            wr_target = head.taken ? head.target : 64'd0;
            wr_valid  = head.taken;
        end
    end

    assign bus.wr_en        = wr_en;
    assign bus.wr_index     = wr_index;
    assign bus.wr_tag       = wr_tag;
    assign bus.wr_target    = wr_target;
    assign bus.wr_valid     = wr_valid;
    assign bus.flush_busy   = (state == FLUSH);
    assign bus.pred_inhibit = (state == FLUSH);
    assign bus.flush_done   = done_q;
endmodule

// File: tb/tb_btb_write_scheduler.sv
// Scoreboard bench for btb_write_scheduler: stimulus queues expected BTB
// writes, a negedge monitor pops and compares every accepted write.
module tb_btb_write_scheduler;
    typedef struct packed {
        logic [4:0]  idx;
        logic [58:0] tag;
        logic [63:0] tgt;
        logic        vld;
    } wr_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    btb_write_scheduler_if #(.LOWER(5)) bus();
    btb_write_scheduler #(.LOWER(5), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    wr_t expq[$];
    int  wr_cyc[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic wr_t upd_exp(input logic [63:0] pc, input logic [63:0] tgt, input logic tk);
        wr_t w;
        w.idx = pc[4:0];
        w.tag = pc[63:5];
        w.tgt = tk ? tgt : 64'd0;
        w.vld = tk;
        return w;
    endfunction

    // monitor: every write the BTB accepts must match the scoreboard head
    always @(negedge clk) begin
        wr_t e;
        if (arst_n) begin
            if (bus.flush_done) done_cnt++;
            if (bus.wr_en && !bus.wr_stall) begin
                wr_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got idx %0d, nothing expected", bus.wr_index);
                end else begin
                    e = expq.pop_front();
                    chk("wr_index", 64'(bus.wr_index), 64'(e.idx));
                    chk("wr_tag", 64'(bus.wr_tag), 64'(e.tag));
                    chk("wr_target", bus.wr_target, e.tgt);
                    chk("wr_valid", 64'(bus.wr_valid), 64'(e.vld));
                end
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.idx = 5'(i);
            w.tag = '0;
            w.tgt = '0;
            w.vld = 1'b0;
            expq.push_back(w);
        end
    endtask

    // call just after a rising edge; returns just after the accepting edge
    task automatic push_upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input bit exp_wr);
        bit ok = 1'b0;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = tk;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.upd_ready;
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no upd_ready for pc %h, expected acceptance", pc);
        end else if (exp_wr) begin
            expq.push_back(upd_exp(pc, tgt, tk));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        bus.flush_req  = 1'b0;
        bus.wr_stall   = 1'b0;

        // reset values
        #12;
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_index", 64'(bus.wr_index), 64'd0);
        chk("rst_wr_target", bus.wr_target, 64'd0);
        chk("rst_flush_busy", 64'(bus.flush_busy), 64'd0);
        chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
        chk("rst_pred_inhibit", 64'(bus.pred_inhibit), 64'd0);
        chk("rst_upd_ready", 64'(bus.upd_ready), 64'd1);
        bus.flush_req = 1'b1;
        #1;
        chk("rst_upd_ready_flush", 64'(bus.upd_ready), 64'd0);
        bus.flush_req = 1'b0;
        @(posedge clk);
        #1 arst_n = 1'b1;
        cyc_n(1);

        // single update: wr_en the cycle after acceptance
        push_upd(64'h1000_0040, 64'h2000, 1'b1, 1'b1);
        chk("lat_wr_en", 64'(bus.wr_en), 64'd1);
        chk("lat_wr_index", 64'(bus.wr_index), 64'd0);
        chk("lat_wr_tag", 64'(bus.wr_tag), 64'h80_0002);
        chk("lat_wr_valid", 64'(bus.wr_valid), 64'd1);
        cyc_n(2);

        // stalled port: FIFO fills at 2, head holds
        bus.wr_stall = 1'b1;
        push_upd(64'h1234, 64'hAAAA, 1'b1, 1'b1);
        push_upd(64'hFFFF_FFFF_FFFF_FFE1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 64'h8000_0000_0000_0067;
        bus.upd_target = 64'h5555;
        bus.upd_taken  = 1'b0;
        @(negedge clk);
        chk("full_upd_ready", 64'(bus.upd_ready), 64'd0);
        chk("stall_hold_idx", 64'(bus.wr_index), 64'h14);
        chk("stall_hold_tgt", bus.wr_target, 64'hAAAA);
        cyc_n(3);
        chk("stall_hold_tag", 64'(bus.wr_tag), 64'h91);
        chk("stall_hold_ready", 64'(bus.upd_ready), 64'd0);
        bus.wr_stall = 1'b0;
        push_upd(64'h8000_0000_0000_0067, 64'h5555, 1'b0, 1'b1);
        cyc_n(3);
        n = wr_cyc.size();
        chk("b2b_gap1", 64'(wr_cyc[n-2] - wr_cyc[n-3]), 64'd1);
        chk("b2b_gap2", 64'(wr_cyc[n-1] - wr_cyc[n-2]), 64'd1);

        // flush with one pending entry (held off by stall so it is never written)
        bus.wr_stall = 1'b1;
        push_upd(64'h40, 64'h77, 1'b1, 1'b0);
        bus.flush_req = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_req = 1'b0;
        bus.wr_stall  = 1'b0;
        push_sweep(32);
        d0 = done_cnt;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("sweep_busy_first", 64'(bus.flush_busy), 64'd1);
                chk("sweep_inhibit_first", 64'(bus.pred_inhibit), 64'd1);
            end
            if (k == 32) begin
                chk("sweep_last_idx", 64'(bus.wr_index), 64'd31);
                chk("sweep_done_early", 64'(bus.flush_done), 64'd0);
            end
            if (k == 33) begin
                chk("sweep_done_pulse", 64'(bus.flush_done), 64'd1);
                chk("sweep_busy_end", 64'(bus.flush_busy), 64'd0);
                chk("sweep_inhibit_end", 64'(bus.pred_inhibit), 64'd0);
            end
        end
        cyc_n(2);
        chk("sweep_done_once", 64'(done_cnt - d0), 64'd1);
        chk("pending_dropped", 64'(bus.wr_en), 64'd0);

        // update and flush together: flush wins
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 64'h9000;
        bus.upd_target = 64'h1;
        bus.upd_taken  = 1'b1;
        bus.flush_req  = 1'b1;
        @(negedge clk);
        chk("flush_wins_ready", 64'(bus.upd_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.flush_req = 1'b0;
        push_sweep(32);
        chk("flush_wins_busy", 64'(bus.flush_busy), 64'd1);
        cyc_n(34);
        chk("flush_wins_no_enq", 64'(bus.wr_en), 64'd0);

        // reset in the middle of a sweep at index 10
        bus.flush_req = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_req = 1'b0;
        push_sweep(10);
        d0 = done_cnt;
        cyc_n(10);
        chk("pre_rst_idx", 64'(bus.wr_index), 64'd10);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid_rst_wr_index", 64'(bus.wr_index), 64'd0);
        chk("mid_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.flush_busy), 64'd0);
        chk("mid_rst_inhibit", 64'(bus.pred_inhibit), 64'd0);
        chk("mid_rst_done", 64'(bus.flush_done), 64'd0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        cyc_n(40);
        chk("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("post_rst_idle", 64'(bus.flush_busy), 64'd0);
        chk("post_rst_empty", 64'(bus.wr_en), 64'd0);
        chk("post_rst_ready", 64'(bus.upd_ready), 64'd1);

        // evict: not-taken update writes valid=0, target=0
        push_upd(64'hDEAD_BEEF_0000_001F, 64'hCAFE, 1'b0, 1'b1);
        chk("evict_idx", 64'(bus.wr_index), 64'd31);
        chk("evict_valid", 64'(bus.wr_valid), 64'd0);
        chk("evict_tgt", bus.wr_target, 64'd0);
        cyc_n(3);

        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        chk("done_total", 64'(done_cnt), 64'd2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
